// File: rtl/fifo_burst_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_if
//   Bundles the sync_fifo read port and the outgoing valid/ready stream of
//   fifo_burst_reader.
//
//   Signals (named from the reader's point of view):
//     i_fifo_empty   sync_fifo o_empty
//     o_fifo_rd_en   sync_fifo i_rd_en
//     i_fifo_data    sync_fifo o_data_out, one cycle after a read
//     o_valid        stream beat valid
//     i_ready        downstream accept
//     o_data         stream data
//     o_last         final beat of the current burst
//     o_burst_count  completed bursts   (FIFO_BURST_READER_STATS_EN only)
//     o_flush_count  timeout-closed bursts (FIFO_BURST_READER_STATS_EN only)
//
//   Modports: master = the reader, slave = its environment.
// -----------------------------------------------------------------------------
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_fifo_empty;
  logic                  o_fifo_rd_en;
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_last;
`ifdef FIFO_BURST_READER_STATS_EN
  logic [15:0]           o_burst_count;
  logic [15:0]           o_flush_count;

  modport master (
    input  i_fifo_empty, i_fifo_data, i_ready,
    output o_fifo_rd_en, o_valid, o_data, o_last, o_burst_count, o_flush_count
  );
  modport slave (
    output i_fifo_empty, i_fifo_data, i_ready,
    input  o_fifo_rd_en, o_valid, o_data, o_last, o_burst_count, o_flush_count
  );
`else
  modport master (
    input  i_fifo_empty, i_fifo_data, i_ready,
    output o_fifo_rd_en, o_valid, o_data, o_last
  );
  modport slave (
    output i_fifo_empty, i_fifo_data, i_ready,
    input  o_fifo_rd_en, o_valid, o_data, o_last
  );
`endif
endinterface

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//   Drains a sync_fifo read port (1-cycle read latency) into a 2-entry buffer
//   and re-emits the words as a valid/ready stream grouped into bursts of
//   BURST_LEN beats, o_last marking the final beat. A word is only offered once
//   its o_last value is known: the burst is full, a following word is already
//   buffered or in flight, or the word has been held for TIMEOUT cycles with
//   the FIFO dry (flush).
//
//   Ports:
//     i_clk   clock
//     i_rst   synchronous reset, active-low
//     bus     fifo_burst_reader_if.master (FIFO read port + output stream)
//
//   Optional feature macro: FIFO_BURST_READER_STATS_EN
//     Adds saturating 16-bit burst and flush counters on the interface.
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  fifo_burst_reader_if.master bus
);

  localparam int              BCW       = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCW-1:0]  BEAT_MAX  = BCW'(BURST_LEN - 1);
  localparam logic [15:0]     TIMEOUT_C = 16'(TIMEOUT);

  // IDLE: buffer empty; HOLD: word held, timer running;
  // STREAM: offering with o_last=0; CLOSE: offering with o_last=1.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    STREAM = 2'd2,
    CLOSE  = 2'd3
  } state_e;

  state_e                state_q,    state_d;
  logic [DATA_WIDTH-1:0] buf0_q,     buf0_d;     // head word
  logic [DATA_WIDTH-1:0] buf1_q,     buf1_d;
  logic [1:0]            buf_cnt_q,  buf_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [BCW-1:0]        beat_q,     beat_d;
  logic [15:0]           timer_q,    timer_d;
  logic                  flush_q,    flush_d;

  logic                  rd_en_s;
  logic                  valid_s;
  logic                  last_s;
  logic                  accept_s;
  logic                  held_s;
  logic [1:0]            slot_s;

  // Reads stop while in reset so nothing can return just after release.
  assign rd_en_s  = i_rst && !bus.i_fifo_empty &&
                    (({1'b0, buf_cnt_q} + {2'b00, inflight_q}) < 3'd2);
  assign accept_s = valid_s && bus.i_ready;

  // A lone word with the FIFO dry and no full burst pending is timing out.
  assign held_s   = (buf_cnt_q == 2'd1) && !inflight_q && bus.i_fifo_empty &&
                    (beat_q != BEAT_MAX) && !flush_q;

  // Slot the returning word lands in, after any head pop this cycle.
  assign slot_s   = buf_cnt_q - {1'b0, accept_s};

  // Decode the presentation state into the stream handshake flags
  always_comb begin
    valid_s = 1'b0;
    last_s  = 1'b0;
    case (state_q)
      IDLE:    begin valid_s = 1'b0; last_s = 1'b0; end
      HOLD:    begin valid_s = 1'b0; last_s = 1'b0; end
      STREAM:  begin valid_s = 1'b1; last_s = 1'b0; end
      CLOSE:   begin valid_s = 1'b1; last_s = 1'b1; end
      default: begin valid_s = 1'b0; last_s = 1'b0; end
    endcase
  end

  // Next-state: buffer, beat counter, hold timer, flush flag and FSM state
  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    buf_cnt_d  = buf_cnt_q + {1'b0, inflight_q} - {1'b0, accept_s};
    inflight_d = rd_en_s;
    beat_d     = beat_q;
    timer_d    = 16'd0;
    flush_d    = flush_q;
    state_d    = state_q;

    if (accept_s) begin
      buf0_d = buf1_q;
    end else begin
      buf0_d = buf0_q;
    end

    if (inflight_q) begin
      if (slot_s == 2'd0) begin
        buf0_d = bus.i_fifo_data;
      end else begin
        buf1_d = bus.i_fifo_data;
      end
    end else begin
      buf1_d = buf1_q;
    end

    if (accept_s) begin
      if (last_s) begin
        beat_d = {BCW{1'b0}};
      end else begin
        beat_d = beat_q + {{(BCW-1){1'b0}}, 1'b1};
      end
    end else begin
      beat_d = beat_q;
    end

    if (held_s) begin
      timer_d = timer_q + 16'd1;
    end else begin
      timer_d = 16'd0;
    end

    if (accept_s && last_s) begin
      flush_d = 1'b0;
    end else if (held_s && (timer_q >= (TIMEOUT_C - 16'd1))) begin
      flush_d = 1'b1;
    end else begin
      flush_d = flush_q;
    end

    // o_last is decided from next-cycle facts and, once offered, none of
    // them can change until the head is accepted, so the beat stays stable.
    if (buf_cnt_d == 2'd0) begin
      state_d = IDLE;
    end else if ((beat_d == BEAT_MAX) || flush_d) begin
      state_d = CLOSE;
    end else if ((buf_cnt_d == 2'd2) || inflight_d) begin
      state_d = STREAM;
    end else begin
      state_d = HOLD;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      buf0_q     <= {DATA_WIDTH{1'b0}};
      buf1_q     <= {DATA_WIDTH{1'b0}};
      buf_cnt_q  <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= {BCW{1'b0}};
      timer_q    <= 16'd0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      buf_cnt_q  <= buf_cnt_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      timer_q    <= timer_d;
      flush_q    <= flush_d;
    end
  end

  assign bus.o_fifo_rd_en = rd_en_s;
  assign bus.o_valid      = valid_s;
  assign bus.o_last       = last_s;
  assign bus.o_data       = buf0_q;

`ifdef FIFO_BURST_READER_STATS_EN
  logic [15:0] burst_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating counters of completed bursts and timeout-closed bursts
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      burst_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (accept_s && last_s && (burst_cnt_q != 16'hFFFF)) begin
        burst_cnt_q <= burst_cnt_q + 16'd1;
      end
      if (accept_s && flush_q && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign bus.o_burst_count = burst_cnt_q;
  assign bus.o_flush_count = flush_cnt_q;
`endif

endmodule
